boot_rom_arb: RTL and testbench

Shared, multi-port boot ROM that replaces the per-core ROM instances with one array.
- Serves NUM_PORTS core fetch ports through a round-robin arbiter.
- Supports incrementing word bursts and reports errors for out-of-range or misaligned requests.
- Sits between each core's boot fetch unit and the memory map.
- Primary image for port 0; ports 1..N-1 are mapped onto a shared secondary (wait-for-wakeup) image.

---
 rtl/boot_rom_arb_if.sv | 28 ++
 rtl/boot_rom_arb.sv | 136 +++++++++++++
 tb/tb_boot_rom_arb.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/boot_rom_arb_if.sv
// Bus bundle between the core boot-fetch ports and the shared boot ROM.
// Handshake: a port holds i_req until it sees its o_gnt bit; request and grant high on the same edge means accepted.
interface boot_rom_arb_if #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 3
);
    logic [NUM_PORTS-1:0]            i_req;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] i_addr;
    logic [NUM_PORTS*LEN_WIDTH-1:0]  i_len;
    logic [NUM_PORTS-1:0]            o_gnt;
    logic [NUM_PORTS-1:0]            o_rvalid;
    logic [DATA_WIDTH-1:0]           o_rdata;
    logic                            o_rlast;
    logic                            o_rerr;
    logic                            o_busy;

    modport master (
        output i_req, i_addr, i_len,
        input  o_gnt, o_rvalid, o_rdata, o_rlast, o_rerr, o_busy
    );

    modport slave (
        input  i_req, i_addr, i_len,
        output o_gnt, o_rvalid, o_rdata, o_rlast, o_rerr, o_busy
    );
endinterface

// File: rtl/boot_rom_arb.sv
// Shared boot ROM with a round-robin arbiter over NUM_PORTS fetch ports and incrementing bursts.
// Port 0 reads the primary image; other ports are offset onto the secondary image at SEC_BASE.
module boot_rom_arb #(
    parameter int NUM_PORTS  = 4,
    parameter int ROM_DEPTH  = 512,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 3,
    parameter int SEC_BASE   = 256
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    boot_rom_arb_if.slave    io_bus,
    output logic             o_dbg_state
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

    state_t                 r_state, w_next;
    logic [PW-1:0]          r_ptr, r_port, w_gidx, w_port;
    logic                   w_found, w_acc, w_issue;
    logic [NUM_PORTS-1:0]   w_gnt;
    logic [ADDR_WIDTH-1:0]  w_gaddr, w_gword, w_beat_addr, r_addr;
    logic [LEN_WIDTH-1:0]   w_glen, r_cnt;
    logic                   w_gmis, r_mis, w_err, w_last;
    logic [DATA_WIDTH-1:0]  w_data;
    logic [NUM_PORTS-1:0]   r_rvalid;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic                   r_rlast, r_rerr;

    function automatic logic [DATA_WIDTH-1:0] rom_word(input int unsigned a);
        logic [31:0] v;
        case (a)
            0:            v = 32'h00000093;
            1:            v = 32'h00000113;
            2:            v = 32'h00000193;
            3:            v = 32'h00000213;
            4:            v = 32'h00000293;
            5:            v = 32'h00000313;
            6:            v = 32'h00000393;
            7:            v = 32'h00000413;
            8:            v = 32'h10010113;
            9:            v = 32'h0100006f;
            SEC_BASE:     v = 32'h10500073;
            SEC_BASE + 1: v = 32'hffdff06f;
            default:      v = 32'h00000013;
        endcase
        return DATA_WIDTH'(v);
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_acc && (w_glen != '0)) w_next = S_BURST;
            S_BURST: if (r_cnt == LEN_WIDTH'(1))  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Search starts one past the last-granted port so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_gnt   = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            if (!w_found && io_bus.i_req[(int'(r_ptr) + i) % NUM_PORTS]) begin
                w_found = 1'b1;
                w_gidx  = PW'((int'(r_ptr) + i) % NUM_PORTS);
            end
        end
        if (r_state == S_IDLE && w_found) w_gnt[w_gidx] = 1'b1;
    end

    assign w_acc   = |(io_bus.i_req & w_gnt);
    assign w_gaddr = io_bus.i_addr[int'(w_gidx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_glen  = io_bus.i_len[int'(w_gidx)*LEN_WIDTH +: LEN_WIDTH];
    assign w_gmis  = (w_gaddr[1:0] != 2'b00);
    // Zero-extended word index plus secondary offset; full-width add cannot wrap.
    assign w_gword = {2'b00, w_gaddr[ADDR_WIDTH-1:2]} +
                     ((w_gidx == '0) ? '0 : ADDR_WIDTH'(SEC_BASE));

    assign w_issue     = w_acc || (r_state == S_BURST);
    assign w_port      = (r_state == S_IDLE) ? w_gidx : r_port;
    assign w_beat_addr = (r_state == S_IDLE) ? w_gword : r_addr;
    assign w_err       = ((r_state == S_IDLE) ? w_gmis : r_mis) ||
                         (w_beat_addr >= ADDR_WIDTH'(ROM_DEPTH));
    assign w_last      = (r_state == S_IDLE) ? (w_glen == '0) : (r_cnt == LEN_WIDTH'(1));
    assign w_data      = w_err ? '0 : rom_word(32'(w_beat_addr));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr    <= PW'(NUM_PORTS - 1);
            r_port   <= '0;
            r_addr   <= '0;
            r_cnt    <= '0;
            r_mis    <= 1'b0;
            r_rvalid <= '0;
            r_rdata  <= '0;
            r_rlast  <= 1'b0;
            r_rerr   <= 1'b0;
        end else begin
            r_rvalid <= '0;
            r_rlast  <= 1'b0;
            r_rerr   <= 1'b0;
            if (w_issue) begin
                r_rvalid[w_port] <= 1'b1;
                r_rdata          <= w_data;
                r_rlast          <= w_last;
                r_rerr           <= w_err;
                r_addr           <= w_beat_addr + ADDR_WIDTH'(1);
            end
            if (w_acc) begin
                r_ptr  <= w_gidx;
                r_port <= w_gidx;
                r_cnt  <= w_glen;
                r_mis  <= w_gmis;
            end else if (r_state == S_BURST) begin
                r_cnt <= r_cnt - LEN_WIDTH'(1);
            end
        end
    end

    assign io_bus.o_gnt    = w_gnt;
    assign io_bus.o_rvalid = r_rvalid;
    assign io_bus.o_rdata  = r_rdata;
    assign io_bus.o_rlast  = r_rlast;
    assign io_bus.o_rerr   = r_rerr;
    assign io_bus.o_busy   = (r_state == S_BURST);
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_boot_rom_arb.sv
// Directed bench for boot_rom_arb: single beats, bursts, arbitration order, errors and mid-burst reset.
module tb_boot_rom_arb;
    localparam int NP = 4;
    localparam int AW = 12;
    localparam int LW = 3;
    localparam int DW = 32;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    logic o_dbg_state;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic [DW-1:0] exp_q[$];

    boot_rom_arb_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    boot_rom_arb #(
        .NUM_PORTS(NP), .ROM_DEPTH(512), .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .SEC_BASE(256)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .io_bus      (bus),
        .o_dbg_state (o_dbg_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a, input logic [LW-1:0] l);
        bus.i_addr[p*AW +: AW] = a;
        bus.i_len[p*LW +: LW]  = l;
    endtask

    task automatic beat(input string tag, input logic [NP-1:0] v, input logic [DW-1:0] d,
                        input logic last, input logic err, input logic busy);
        chk({tag, "_rvalid"}, bus.o_rvalid, v);
        chk({tag, "_rdata"},  bus.o_rdata,  d);
        chk({tag, "_rlast"},  bus.o_rlast,  last);
        chk({tag, "_rerr"},   bus.o_rerr,   err);
        chk({tag, "_busy"},   bus.o_busy,   busy);
    endtask

    initial begin
        bus.i_req  = '0;
        bus.i_addr = '0;
        bus.i_len  = '0;
        repeat (3) @(posedge i_clk);
        #1;
        beat("rst", 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_gnt", bus.o_gnt, 4'b0000);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Port 0, single beat from word 0.
        bus.i_req = 4'b0001;
        set_port(0, 12'h000, 3'd0);
        #1 chk("t1_gnt", bus.o_gnt, 4'b0001);
        step();
        bus.i_req = '0;
        beat("t1", 4'b0001, 32'h00000093, 1'b1, 1'b0, 1'b0);

        // Port 1, two-beat burst from the secondary image; gnt stays low while busy.
        bus.i_req = 4'b0010;
        set_port(1, 12'h000, 3'd1);
        #1 chk("t2_gnt", bus.o_gnt, 4'b0010);
        step();
        bus.i_req = 4'b0001;
        #1 chk("t2_gnt_busy", bus.o_gnt, 4'b0000);
        beat("t2_b0", 4'b0010, 32'h10500073, 1'b0, 1'b0, 1'b1);
        bus.i_req = '0;
        step();
        beat("t2_b1", 4'b0010, 32'hffdff06f, 1'b1, 1'b0, 1'b0);
        step();
        beat("t2_idle", 4'b0000, 32'hffdff06f, 1'b0, 1'b0, 1'b0);

        // Ports 0 and 2 held together: pointer sits at 1, so port 2 goes first, then alternation.
        set_port(0, 12'h008, 3'd0);
        set_port(2, 12'h004, 3'd0);
        bus.i_req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("t3_gnt%0d", i), bus.o_gnt, (i % 2 == 0) ? 4'b0100 : 4'b0001);
            step();
            beat($sformatf("t3_b%0d", i), (i % 2 == 0) ? 4'b0100 : 4'b0001,
                 (i % 2 == 0) ? 32'hffdff06f : 32'h00000193, 1'b1, 1'b0, 1'b0);
        end
        bus.i_req = '0;

        // Burst crossing the top of the ROM: word 511 is fine, word 512 errors.
        set_port(0, 12'h7FC, 3'd1);
        bus.i_req = 4'b0001;
        #1 chk("t4_gnt", bus.o_gnt, 4'b0001);
        step();
        bus.i_req = '0;
        beat("t4_b0", 4'b0001, 32'h00000013, 1'b0, 1'b0, 1'b1);
        step();
        beat("t4_b1", 4'b0001, 32'h0, 1'b1, 1'b1, 1'b0);

        // Port 1 at 0x400 lands on word 512 after the secondary offset.
        set_port(1, 12'h400, 3'd0);
        bus.i_req = 4'b0010;
        #1 chk("t4b_gnt", bus.o_gnt, 4'b0010);
        step();
        bus.i_req = '0;
        beat("t4b", 4'b0010, 32'h0, 1'b1, 1'b1, 1'b0);

        // Misaligned start: every beat errors, length still honoured.
        set_port(3, 12'h002, 3'd2);
        bus.i_req = 4'b1000;
        #1 chk("t5_gnt", bus.o_gnt, 4'b1000);
        step();
        bus.i_req = '0;
        beat("t5_b0", 4'b1000, 32'h0, 1'b0, 1'b1, 1'b1);
        step();
        beat("t5_b1", 4'b1000, 32'h0, 1'b0, 1'b1, 1'b1);
        step();
        beat("t5_b2", 4'b1000, 32'h0, 1'b1, 1'b1, 1'b0);

        // Eight-beat burst aborted by reset after beat 3.
        exp_q = '{32'h00000093, 32'h00000113, 32'h00000193, 32'h00000213};
        set_port(0, 12'h000, 3'd7);
        bus.i_req = 4'b0001;
        #1 chk("t6_gnt", bus.o_gnt, 4'b0001);
        step();
        bus.i_req = '0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            chk($sformatf("t6_rvalid%0d", i), bus.o_rvalid, 4'b0001);
            chk($sformatf("t6_rdata%0d", i), bus.o_rdata, exp_q.pop_front());
            chk($sformatf("t6_rlast%0d", i), bus.o_rlast, 1'b0);
        end
        #1 i_rst_n = 1'b0;
        #1 beat("t6_rst", 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t6_rst_state", o_dbg_state, 1'b0);
        step();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("t6_quiet_rvalid%0d", i), bus.o_rvalid, 4'b0000);
            chk($sformatf("t6_quiet_state%0d", i), o_dbg_state, 1'b0);
        end

        // After reset all ports request; port 0 must win.
        for (int p = 0; p < NP; p++) set_port(p, 12'h000, 3'd0);
        bus.i_req = 4'b1111;
        #1 chk("t7_gnt", bus.o_gnt, 4'b0001);
        step();
        bus.i_req = '0;
        beat("t7", 4'b0001, 32'h00000093, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
